// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch front-end types: FSM state encoding and the queued {pc, instr} entry layout.
package fetch_prefetch_unit_pkg;

  localparam int unsigned RV_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous FIFO with push/pop/flush; pointers wrap modulo DEPTH (power of two).
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  assign do_pop = pop & ~empty;
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(do_pop);
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !flush));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC sequencer, one outstanding I-cache request, prefetch queue
// toward ID, and EX redirect handling with discard of an in-flight response.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = 'h60
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t     state;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  pend_pc;

  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     count_next;
  logic [2*XLEN-1:0] q_head;

  // Redirect dominates: it suppresses both the push of live data and any ID pop.
  assign q_push     = (state == FETCH) & imem_resp & ~redirect;
  assign q_pop      = id_ready & ~q_empty & ~redirect;
  assign count_next = q_count + CW'(q_push) - CW'(q_pop);

  assign imem_read    = (state != IDLE);
  assign imem_address = req_pc;
  assign id_valid     = ~q_empty;
  assign id_pc        = q_head[2*XLEN-1:XLEN];
  assign id_instr     = q_head[XLEN-1:0];

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   ({req_pc, imem_rdata}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_pc  <= RESET_PC;
      pend_pc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            req_pc <= redirect_pc;
            state  <= FETCH;
          // Post-pop occupancy lets a single ID pop restart fetch on the very next cycle.
          end else if (count_next < CW'(DEPTH)) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (redirect && imem_resp) begin
            req_pc <= redirect_pc;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
            state   <= DROP;
          end else if (imem_resp) begin
            req_pc <= req_pc + XLEN'(4);
            state  <= (count_next < CW'(DEPTH)) ? FETCH : IDLE;
          end
        end
        DROP: begin
          if (imem_resp) begin
            req_pc <= redirect ? redirect_pc : pend_pc;
            state  <= FETCH;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a combinational instruction memory model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        resp_en;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DEPTH    (4),
    .XLEN     (32),
    .RESET_PC (32'h0000_0060)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  always_comb begin
    imem_rdata = mem_word(imem_address);
    imem_resp  = imem_read & resp_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    resp_en     = 1'b0;
    #2;
    check("rst_read",  32'(imem_read), 32'd0);
    check("rst_valid", 32'(id_valid),  32'd0);
    check("rst_pc",    id_pc,          32'd0);
    check("rst_instr", id_instr,       32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // 1: back-to-back streaming with 0-wait memory
    do_reset();
    resp_en = 1'b1; id_ready = 1'b1;
    step();
    check("t1_read0", 32'(imem_read), 32'd1);
    check("t1_addr0", imem_address, 32'h60);
    check("t1_valid0", 32'(id_valid), 32'd0);
    step();
    check("t1_addr1", imem_address, 32'h64);
    check("t1_valid1", 32'(id_valid), 32'd1);
    check("t1_pc1", id_pc, 32'h60);
    check("t1_instr1", id_instr, mem_word(32'h60));
    step();
    check("t1_addr2", imem_address, 32'h68);
    check("t1_pc2", id_pc, 32'h64);
    check("t1_instr2", id_instr, mem_word(32'h64));
    step();
    check("t1_addr3", imem_address, 32'h6C);
    check("t1_pc3", id_pc, 32'h68);

    // 2: queue fills to DEPTH, then one pop restarts fetch at 0x70
    do_reset();
    resp_en = 1'b1; id_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("t2_read", 32'(imem_read), 32'd1);
      check("t2_addr", imem_address, 32'h60 + 32'(4 * i));
      step();
    end
    check("t2_full_read", 32'(imem_read), 32'd0);
    check("t2_full_pc", id_pc, 32'h60);
    step();
    check("t2_hold_read", 32'(imem_read), 32'd0);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("t2_restart_read", 32'(imem_read), 32'd1);
    check("t2_restart_addr", imem_address, 32'h70);
    check("t2_restart_pc", id_pc, 32'h64);

    // 3: redirect during a 3-cycle wait on 0x6C
    do_reset();
    resp_en = 1'b1; id_ready = 1'b1;
    step(); step(); step(); step();
    check("t3_addr_wait", imem_address, 32'h6C);
    resp_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("t3_drop_addr", imem_address, 32'h6C);
    check("t3_drop_read", 32'(imem_read), 32'd1);
    check("t3_drop_valid", 32'(id_valid), 32'd0);
    step();
    check("t3_drop_addr2", imem_address, 32'h6C);
    check("t3_drop_valid2", 32'(id_valid), 32'd0);
    resp_en = 1'b1;
    step();
    check("t3_new_addr", imem_address, 32'h200);
    check("t3_discard_valid", 32'(id_valid), 32'd0);
    step();
    check("t3_next_addr", imem_address, 32'h204);
    check("t3_head_valid", 32'(id_valid), 32'd1);
    check("t3_head_pc", id_pc, 32'h200);

    // 4: redirect with resp and id_ready together; then req_pc wrap
    do_reset();
    resp_en = 1'b1; id_ready = 1'b0;
    step(); step(); step();
    check("t4_pre_valid", 32'(id_valid), 32'd1);
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h123;
    step();
    redirect = 1'b0; id_ready = 1'b0;
    check("t4_flush_valid", 32'(id_valid), 32'd0);
    check("t4_addr", imem_address, 32'h123);
    step();
    check("t4_valid", 32'(id_valid), 32'd1);
    check("t4_pc", id_pc, 32'h123);
    check("t4_instr", id_instr, mem_word(32'h123));
    check("t4_addr_next", imem_address, 32'h127);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("t4_wrap_addr0", imem_address, 32'hFFFF_FFFC);
    step();
    check("t4_wrap_addr1", imem_address, 32'h0);
    check("t4_wrap_pc", id_pc, 32'hFFFF_FFFC);

    // 5: two redirects during one DROP
    do_reset();
    resp_en = 1'b0; id_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    check("t5_drop_addr", imem_address, 32'h60);
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    check("t5_drop_addr2", imem_address, 32'h60);
    resp_en = 1'b1;
    step();
    check("t5_new_addr", imem_address, 32'h400);
    check("t5_valid", 32'(id_valid), 32'd0);
    id_ready = 1'b0;
    step();
    check("t5_next_addr", imem_address, 32'h404);
    check("t5_pc", id_pc, 32'h400);

    // 6: asynchronous reset during a live fetch with a loaded queue
    do_reset();
    resp_en = 1'b1; id_ready = 1'b0;
    step(); step(); step(); step();
    resp_en = 1'b0;
    step();
    check("t6_pre_read", 32'(imem_read), 32'd1);
    check("t6_pre_valid", 32'(id_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_read", 32'(imem_read), 32'd0);
    check("t6_rst_valid", 32'(id_valid), 32'd0);
    step();
    rst_n = 1'b1;
    resp_en = 1'b1;
    step();
    check("t6_refetch_read", 32'(imem_read), 32'd1);
    check("t6_refetch_addr", imem_address, 32'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
